// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: operand-A forwarding
// encodings, sequencing FSM states, and instruction field positions.
package pipe_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_EX = 2'b01;
   localparam logic [1:0] FWD_WB = 2'b10;

   localparam int CNT_W = 3;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   // Field positions for a given instruction / register-address width.
   function automatic int jump_pos(input int instr_w);
      return instr_w - 1;
   endfunction

   function automatic int imm_pos(input int instr_w);
      return instr_w - 2;
   endfunction

   function automatic int rd_hi(input int reg_aw);
      return 2 * reg_aw - 1;
   endfunction

   function automatic int rd_lo(input int reg_aw);
      return reg_aw;
   endfunction

   function automatic int rs_hi(input int reg_aw);
      return reg_aw - 1;
   endfunction

   localparam int DEF_INSTR_W = 8;
   localparam int DEF_REG_AW  = 3;
   localparam int JUMP_POS    = jump_pos(DEF_INSTR_W);
   localparam int IMM_POS     = imm_pos(DEF_INSTR_W);
   localparam int RD_HI       = rd_hi(DEF_REG_AW);
   localparam int RD_LO       = rd_lo(DEF_REG_AW);
   localparam int RS_HI       = rs_hi(DEF_REG_AW);

endpackage

// File: rtl/pipe_hazard_detect.sv
// Register hazard detection for the ID-stage source operand.
// Build option CTRL_FWD_EN: when defined, hazards resolve by forwarding
// (fwd_a); otherwise they raise hazard_stall until the producer retires.
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 3
) (
   input  logic              chk_en,
   input  logic [REG_AW-1:0] rs,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              wb_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic              hazard_stall
);

   logic exm;
   logic wbm;

   // Match the source register against in-flight writers in EX and WB.
   always_comb begin
      exm = chk_en & ex_valid & ex_reg_write & (ex_rd == rs);
      wbm = chk_en & wb_valid & wb_reg_write & (wb_rd == rs);
   end

   // Resolve: the younger producer (EX) has priority over WB.
   always_comb begin
      fwd_a        = FWD_RF;
      hazard_stall = 1'b0;
`ifdef CTRL_FWD_EN
      if (exm)
         fwd_a = FWD_EX;
      else if (wbm)
         fwd_a = FWD_WB;
`else
      hazard_stall = exm | wbm;
`endif
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, EX/WB control pipeline, jump squash
// sequencing and register hazard handling.
// Build option CTRL_FWD_EN selects forwarding instead of hazard stalls.
//
// state  | meaning
// RUN    | normal issue; a taken jump loads the squash counter
// SQUASH | fetch slots after a jump are discarded, one per non-stalled cycle
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int INSTR_W      = 8,
   parameter int REG_AW       = 3,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_code,
   input  logic               instr_valid,
   input  logic               stall,
   output logic               pc_src,
   output logic               imm_sel,
   output logic               alu_src,
   output logic               reg_write,
   output logic               squashing,
   output logic               ex_valid,
   output logic               ex_alu_src,
   output logic               ex_reg_write,
   output logic [REG_AW-1:0]  ex_rd,
   output logic               wb_valid,
   output logic               wb_reg_write,
   output logic [REG_AW-1:0]  wb_rd,
   output logic [1:0]         fwd_a,
   output logic               hazard_stall
);

   localparam int JP  = jump_pos(INSTR_W);
   localparam int IP  = imm_pos(INSTR_W);
   localparam int RDH = rd_hi(REG_AW);
   localparam int RDL = rd_lo(REG_AW);
   localparam int RSH = rs_hi(REG_AW);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  next_cnt;
   logic              id_ok;
   logic              jump;
   logic              imm;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs;
   logic              eff_stall;

   assign jump = instr_code[JP];
   assign imm  = instr_code[IP];
   assign rd   = instr_code[RDH:RDL];
   assign rs   = instr_code[RSH:0];

   pipe_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .chk_en       (id_ok & ~jump),
      .rs           (rs),
      .ex_valid     (ex_valid),
      .ex_reg_write (ex_reg_write),
      .ex_rd        (ex_rd),
      .wb_valid     (wb_valid),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .fwd_a        (fwd_a),
      .hazard_stall (hazard_stall)
   );

   // ID-stage decode; slots fetched during SQUASH never count as instructions.
   always_comb begin
      id_ok     = instr_valid & (state == RUN);
      eff_stall = stall | hazard_stall;
      pc_src    = id_ok & jump & ~eff_stall;
      imm_sel   = id_ok & jump;
      alu_src   = id_ok & imm;
      reg_write = id_ok & ~jump;
      squashing = (state == SQUASH);
   end

   // Squash sequencing: counter only advances on non-stalled cycles.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         RUN: begin
            if (pc_src) begin
               next_state = SQUASH;
               next_cnt   = CNT_W'(FLUSH_CYCLES);
            end
         end
         SQUASH: begin
            if (!eff_stall) begin
               next_cnt = cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   // FSM state and squash counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // EX stage: capture ID controls, or insert a bubble while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_rd        <= '0;
      end else if (eff_stall) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
      end else begin
         ex_valid     <= id_ok;
         ex_alu_src   <= alu_src;
         ex_reg_write <= reg_write;
         ex_rd        <= rd;
      end
   end

   // WB stage: unconditionally follows EX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
      end else begin
         wb_valid     <= ex_valid;
         wb_reg_write <= ex_reg_write;
         wb_rd        <= ex_rd;
      end
   end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control unit for the pipelined processor. It decodes the instruction code in the ID stage into PC-source, immediate-select, ALU-source and register-write controls. It carries those controls through registered EX and WB stages with valid bits, and squashes a programmable number of fetch slots after a taken jump. It also detects register hazards and resolves them by forwarding-select or by stall request.

## Interface
- INSTR_W, 8, instruction code width; must be ≥ 2*REG_AW+2
- REG_AW, 3, register-address width
- FLUSH_CYCLES, 1, fetch slots squashed after a taken jump; legal range 1..7
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- instr_code  in  INSTR_W  ID-stage instruction: [INSTR_W-1] jump, [INSTR_W-2] imm, [2*REG_AW-1:REG_AW] rd, [REG_AW-1:0] rs
- instr_valid  in  1  instr_code holds a real instruction
- stall  in  1  external stall; ID must not advance
- pc_src  out  1  take jump target this cycle
- imm_sel  out  1  immediate select, ID stage
- alu_src  out  1  ALU B from immediate, ID stage
- reg_write  out  1  ID instruction writes rd
- squashing  out  1  FSM in SQUASH
- ex_valid, ex_alu_src, ex_reg_write  out  1 each  EX-stage registered controls
- ex_rd  out  REG_AW  EX destination
- wb_valid, wb_reg_write  out  1 each  WB-stage registered controls
- wb_rd  out  REG_AW  WB destination
- fwd_a  out  2  operand-A source: 00 register file, 01 EX result, 10 WB result
- hazard_stall  out  1  stall request (non-forwarding build only)

## Operation
- id_ok = instr_valid & (state==RUN).
- Decoded controls are combinational:
  - pc_src = id_ok & jump & ~eff_stall
  - imm_sel = id_ok & jump
  - alu_src = id_ok & imm
  - reg_write = id_ok & ~jump
- eff_stall = stall | hazard_stall.
- FSM states:
  - RUN: a taken jump (pc_src=1) loads cnt=FLUSH_CYCLES and moves to SQUASH.
  - SQUASH: each non-stalled cycle decrements cnt. A non-stalled cycle with cnt==1 returns to RUN. While stalled, cnt is frozen.
  - Every instruction presented while in SQUASH is treated as invalid.
- EX register:
  - When eff_stall=0: ex_valid<=id_ok, ex_alu_src<=alu_src, ex_reg_write<=reg_write, ex_rd<=rd.
  - When eff_stall=1: bubble, with ex_valid<=0 and ex_reg_write<=0; ex_rd holds.
- WB register always takes EX: wb_valid<=ex_valid, wb_reg_write<=ex_reg_write, wb_rd<=ex_rd.
- Hazard match:
  - exm = ex_valid & ex_reg_write & (ex_rd==rs)
  - wbm = wb_valid & wb_reg_write & (wb_rd==rs)
  - Both are evaluated only when id_ok=1 and jump=0.
- Reset value of every output and register is 0. State resets to RUN and cnt to 0. Reset mid-SQUASH returns to RUN immediately; in-flight EX/WB contents are discarded.

## Timing
- Decoded ID controls and fwd_a/hazard_stall are valid in the same cycle as instr_code.
- EX outputs appear 1 cycle after ID; WB outputs appear 2 cycles after ID, or later if stall bubbles are inserted.
- A jump in cycle N squashes exactly FLUSH_CYCLES non-stalled slots starting at N+1.
- A jump presented while stalled is not taken (pc_src=0) and does not enter SQUASH. It is retaken when the stall drops.
- Simultaneous exm and wbm: EX wins (fwd_a=01).

## Configuration
- CTRL_FWD_EN defined:
  - fwd_a = 01 if exm, else 10 if wbm, else 00.
  - hazard_stall tied 0.
- CTRL_FWD_EN undefined:
  - fwd_a tied 00.
  - hazard_stall = exm | wbm. It feeds eff_stall internally and holds until the producer retires from WB.
- hazard_stall depends only on registered state and instr_code, so there is no combinational loop.

## Structure
- Package pipe_ctrl_pkg contains:
  - fwd_a encodings FWD_RF/FWD_EX/FWD_WB
  - FSM state enum RUN/SQUASH
  - field-position localparams derived from INSTR_W and REG_AW
- One sub-module, pipe_hazard_detect: combinational exm/wbm compare and fwd_a/hazard_stall generation, with the macro applied there.

## Test plan
- Reset asserted mid-SQUASH with FLUSH_CYCLES=3 -> all outputs 0 and squashing=0 on the next edge; the first valid instruction decodes normally.
- Default parameters, instr_code=8'h1A valid, with rd=3, rs=2, no hazard -> reg_write=1, alu_src=0, fwd_a=00; ex_rd=3 one cycle later; wb_reg_write=1 two cycles later.
- Jump 8'h80 with FLUSH_CYCLES=2, followed by 3 valid instructions -> pc_src=1 for 1 cycle, squashing=1 for 2 cycles, and exactly the first 2 instructions give ex_valid=0.
- Jump then stall=1 for 2 cycles during SQUASH, FLUSH_CYCLES=1 -> squashing stays 1 across the stall and drops after the first non-stalled cycle.
- Forwarding build: write r3 (8'h18), then an instruction reading rs=3 -> fwd_a=01; one cycle later with a 1-bubble gap -> fwd_a=10; writes to r3 in both EX and WB -> fwd_a=01.
- Non-forwarding build: same back-to-back r3 dependency -> hazard_stall=1 for 2 cycles, ex_valid=0 bubbles, then the dependent instruction issues with hazard_stall=0.
